decode_stage: RTL and testbench

- RV32I decode stage. Sits directly upstream of the 32-entry register file.
- Drives the register-file read addresses combinationally and takes back the read data.
- Bypasses same-cycle writeback data, generates immediates and flags illegal opcodes.
- Holds the decoded bundle in a single-entry pipeline register with a valid/ready handshake to execute.

---
 rtl/decode_stage.sv | 152 +++++++++++++++
 tb/tb_decode_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: register-file addressing, writeback bypass, immediate generation
// and a single-entry output register with a valid/ready handshake to execute.
module decode_stage #(
  parameter int unsigned data_width = 32,
  parameter int unsigned num_reg    = 32,
  parameter int unsigned idx_width  = $clog2(num_reg)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in_pc,
  input  logic [31:0]           in_instr,
  input  logic                  flush,
  output logic [idx_width-1:0]  rf_rs1,
  output logic [idx_width-1:0]  rf_rs2,
  input  logic [data_width-1:0] rf_rs1v,
  input  logic [data_width-1:0] rf_rs2v,
  input  logic                  wb_en,
  input  logic [idx_width-1:0]  wb_rd,
  input  logic [data_width-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out_pc,
  output logic [6:0]            out_opcode,
  output logic [2:0]            out_funct3,
  output logic                  out_funct7b5,
  output logic [idx_width-1:0]  out_rd,
  output logic [idx_width-1:0]  out_rs1,
  output logic [idx_width-1:0]  out_rs2,
  output logic [data_width-1:0] out_rs1v,
  output logic [data_width-1:0] out_rs2v,
  output logic [data_width-1:0] out_imm,
  output logic                  out_illegal
);

  logic                  valid_q, illegal_q, funct7b5_q;
  logic [data_width-1:0] pc_q, rs1v_q, rs2v_q, imm_q;
  logic [6:0]            opcode_q;
  logic [2:0]            funct3_q;
  logic [idx_width-1:0]  rd_q, rs1_q, rs2_q;

  logic                  legal, use_rs1, use_rs2, has_rd, accept, wb_hit;
  logic [31:0]           imm32;
  logic [idx_width-1:0]  rs1_idx, rs2_idx, rd_idx;
  logic [data_width-1:0] rs1_val, rs2_val;

  assign rf_rs1   = idx_width'(in_instr[19:15]);
  assign rf_rs2   = idx_width'(in_instr[24:20]);
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign wb_hit   = wb_en && (wb_rd != '0);

  always_comb begin
    legal   = 1'b1;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    has_rd  = 1'b1;
    imm32   = '0;
    case (in_instr[6:0])
      7'b0110111, 7'b0010111: begin // LUI, AUIPC
        use_rs1 = 1'b0;
        imm32   = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin // JAL
        use_rs1 = 1'b0;
        imm32   = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: begin // I-type
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b1100011: begin // BRANCH
        use_rs2 = 1'b1;
        has_rd  = 1'b0;
        imm32   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0100011: begin // STORE
        use_rs2 = 1'b1;
        has_rd  = 1'b0;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b0110011: use_rs2 = 1'b1;
      7'b0001111: has_rd = 1'b0;
      default: begin
        legal   = 1'b0;
        use_rs1 = 1'b0;
        has_rd  = 1'b0;
      end
    endcase
  end

  // Masked indices read as x0, so their operands collapse to zero below.
  assign rs1_idx = use_rs1 ? rf_rs1 : '0;
  assign rs2_idx = use_rs2 ? rf_rs2 : '0;
  assign rd_idx  = has_rd ? idx_width'(in_instr[11:7]) : '0;
  assign rs1_val = (wb_hit && wb_rd == rs1_idx) ? wb_data :
                   (rs1_idx == '0) ? '0 : rf_rs1v;
  assign rs2_val = (wb_hit && wb_rd == rs2_idx) ? wb_data :
                   (rs2_idx == '0) ? '0 : rf_rs2v;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
      funct7b5_q <= 1'b0;
      pc_q       <= '0;
      rs1v_q     <= '0;
      rs2v_q     <= '0;
      imm_q      <= '0;
      opcode_q   <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q    <= 1'b1;
      illegal_q  <= !legal;
      funct7b5_q <= in_instr[30];
      pc_q       <= in_pc;
      rs1v_q     <= rs1_val;
      rs2v_q     <= rs2_val;
      imm_q      <= data_width'(imm32);
      opcode_q   <= in_instr[6:0];
      funct3_q   <= in_instr[14:12];
      rd_q       <= rd_idx;
      rs1_q      <= rs1_idx;
      rs2_q      <= rs2_idx;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end else if (valid_q) begin
      // Stalled bundle tracks writebacks so its operands never go stale.
      if (wb_hit && wb_rd == rs1_q) rs1v_q <= wb_data;
      if (wb_hit && wb_rd == rs2_q) rs2v_q <= wb_data;
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_opcode   = opcode_q;
  assign out_funct3   = funct3_q;
  assign out_funct7b5 = funct7b5_q;
  assign out_rd       = rd_q;
  assign out_rs1      = rs1_q;
  assign out_rs2      = rs2_q;
  assign out_rs1v     = rs1v_q;
  assign out_rs2v     = rs2v_q;
  assign out_imm      = imm_q;
  assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage: handshake, bypass, immediates, stall, flush, reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, wb_en, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, rf_rs1v, rf_rs2v, wb_data;
  logic [4:0]  rf_rs1, rf_rs2, wb_rd, out_rd, out_rs1, out_rs2;
  logic [31:0] out_pc, out_rs1v, out_rs2v, out_imm;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5, out_illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instr(in_instr), .flush(flush), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rs1v(rf_rs1v), .rf_rs2v(rf_rs2v), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs1v(out_rs1v), .out_rs2v(out_rs2v),
    .out_imm(out_imm), .out_illegal(out_illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] instr);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; flush = 1'b0;
    rf_rs1v = '0; rf_rs2v = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    checks++;
    if ({out_pc, out_rs1v, out_rs2v, out_imm, out_opcode, out_funct3, out_funct7b5, out_rd,
         out_rs1, out_rs2, out_illegal} !== '0) begin
      failures++; $display("FAIL reset_fields got pc=%h imm=%h rd=%0d want all zero", out_pc, out_imm, out_rd);
    end
  endtask

  task automatic test_addi();
    present(32'h100, 32'h00500093); rf_rs1v = 32'h1234;
    step();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0b want=1", out_valid); end
    checks++; if (out_rd !== 5'd1) begin failures++; $display("FAIL addi_rd got=%0d want=1", out_rd); end
    checks++; if (out_rs1 !== 5'd0 || out_rs1v !== 32'h0) begin failures++; $display("FAIL addi_rs1 got=%0d/%h want=0/0", out_rs1, out_rs1v); end
    checks++; if (out_imm !== 32'h5) begin failures++; $display("FAIL addi_imm got=%h want=00000005", out_imm); end
    checks++; if (out_illegal !== 1'b0 || out_opcode !== 7'h13 || out_pc !== 32'h100) begin
      failures++; $display("FAIL addi_misc got ill=%0b op=%h pc=%h want 0/13/100", out_illegal, out_opcode, out_pc); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL addi_drain got=%0b want=0", out_valid); end
  endtask

  task automatic test_bypass();
    present(32'h104, 32'h00218233); rf_rs1v = 32'h11; rf_rs2v = 32'h22;
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    #1;
    checks++; if (rf_rs1 !== 5'd3 || rf_rs2 !== 5'd2) begin failures++; $display("FAIL rf_addr got=%0d/%0d want=3/2", rf_rs1, rf_rs2); end
    step();
    checks++; if (out_rs1v !== 32'hDEADBEEF || out_rs2v !== 32'h22) begin
      failures++; $display("FAIL bypass_hit got=%h/%h want=deadbeef/00000022", out_rs1v, out_rs2v); end
    checks++; if (out_rd !== 5'd4 || out_rs1 !== 5'd3 || out_rs2 !== 5'd2) begin
      failures++; $display("FAIL add_idx got=%0d/%0d/%0d want=4/3/2", out_rd, out_rs1, out_rs2); end
    wb_rd = 5'd0;
    step();
    checks++; if (out_rs1v !== 32'h11) begin failures++; $display("FAIL bypass_x0 got=%h want=00000011", out_rs1v); end
    wb_en = 1'b0;
  endtask

  task automatic test_imm();
    present(32'h108, 32'hFE000EE3);
    step();
    checks++; if (out_imm !== 32'hFFFFFFFC || out_rd !== 5'd0) begin
      failures++; $display("FAIL beq got imm=%h rd=%0d want=fffffffc/0", out_imm, out_rd); end
    present(32'h10C, 32'hABCDE2B7);
    step();
    checks++; if (out_imm !== 32'hABCDE000) begin failures++; $display("FAIL lui_imm got=%h want=abcde000", out_imm); end
    checks++; if (out_rs1 !== 5'd0 || out_rs2 !== 5'd0 || out_rd !== 5'd5) begin
      failures++; $display("FAIL lui_idx got=%0d/%0d/%0d want=0/0/5", out_rs1, out_rs2, out_rd); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_stall();
    present(32'h200, 32'h40838333); rf_rs1v = 32'h77; rf_rs2v = 32'h88; out_ready = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || out_rs2v !== 32'h88 || out_funct7b5 !== 1'b1) begin
      failures++; $display("FAIL sub_capture got v=%0b rs2v=%h f7=%0b want 1/88/1", out_valid, out_rs2v, out_funct7b5); end
    present(32'h204, 32'h00500093);
    for (int c = 1; c <= 3; c++) begin
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready c=%0d got=%0b want=0", c, in_ready); end
      if (c == 2) begin wb_en = 1'b1; wb_rd = 5'd8; wb_data = 32'h55; end
      step();
      wb_en = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_rd !== 5'd6 || out_rs1v !== 32'h77 ||
          out_rs2v !== ((c >= 2) ? 32'h55 : 32'h88)) begin
        failures++; $display("FAIL stall_hold c=%0d got pc=%h rd=%0d rs1v=%h rs2v=%h", c, out_pc, out_rd, out_rs1v, out_rs2v);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%0b want=1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL release_valid got=%0b want=0", out_valid); end
  endtask

  task automatic test_flush_reset();
    present(32'h300, 32'h00500093); out_ready = 1'b0;
    step();
    present(32'h304, 32'hABCDE2B7); flush = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b want=0", out_valid); end
    flush = 1'b0; in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_nocapture got=%0b want=0", out_valid); end
    present(32'h308, 32'h00218233); rf_rs1v = 32'h99;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({out_valid, out_pc, out_rs1v, out_rs2v, out_imm, out_opcode, out_funct3, out_rd,
         out_rs1, out_rs2} !== '0) begin
      failures++; $display("FAIL rst_stall got v=%0b pc=%h rs1v=%h want all zero", out_valid, out_pc, out_rs1v);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_illegal();
    rf_rs1v = 32'hAAAA; rf_rs2v = 32'hBBBB;
    present(32'h400, 32'h0000007F);
    step();
    checks++; if (out_illegal !== 1'b1 || out_rd !== 5'd0 || out_imm !== 32'h0 || out_rs1v !== 32'h0) begin
      failures++; $display("FAIL illegal_7f got ill=%0b rd=%0d imm=%h rs1v=%h", out_illegal, out_rd, out_imm, out_rs1v); end
    present(32'h404, 32'h00000000);
    step();
    checks++; if (out_illegal !== 1'b1 || out_rd !== 5'd0 || out_imm !== 32'h0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL illegal_zero got ill=%0b rd=%0d imm=%h v=%0b", out_illegal, out_rd, out_imm, out_valid); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] instrs [4];
    instrs[0] = 32'h00500093; instrs[1] = 32'h00218233;
    instrs[2] = 32'hFE000EE3; instrs[3] = 32'hABCDE2B7;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      present(32'h500 + 32'(i * 4), instrs[i]);
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h500 + 32'(i * 4) || out_opcode !== instrs[i][6:0]) begin
        failures++; $display("FAIL stream i=%0d got v=%0b pc=%h op=%h", i, out_valid, out_pc, out_opcode); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_end got=%0b want=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_bypass();
    test_imm();
    test_stall();
    test_flush_reset();
    test_illegal();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
